// File: rtl/cache_mem_arbiter_if.sv
// Cache <-> memory request bundle for one core: icache fill, dcache load/store, RAM port.
// The arbiter takes the slave view; caches plus RAM model together form the master view.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises icache fills and dcache loads/stores onto one single-ported RAM.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both caches request together.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    cache_mem_arbiter_if.slave    bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, ISVC, DSVC} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_dreq;
    logic              w_grant_d;
    logic              w_icomp;
    logic              w_dcomp;
    logic [ADDR_W-1:0] w_ramaddr;
    logic [DATA_W-1:0] w_ramstore;

    assign w_dreq = bus.dREN | bus.dWEN;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    logic r_last_grant;

    // On a tie the side that did not complete last wins, so dcache streaming can't starve fills.
    assign w_grant_d = w_dreq && !(bus.iREN && (r_last_grant == GRANT_DATA));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_last_grant <= GRANT_INSTR;
        else if (w_icomp)
            r_last_grant <= GRANT_INSTR;
        else if (w_dcomp)
            r_last_grant <= GRANT_DATA;
    end
`else
    assign w_grant_d = w_dreq;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_icomp    = 1'b0;
        w_dcomp    = 1'b0;
        w_ramaddr  = '0;
        w_ramstore = '0;
        bus.iwait  = 1'b1;
        bus.dwait  = 1'b1;
        bus.iload  = '0;
        bus.dload  = '0;
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_d)
                    w_next = DSVC;
                else if (bus.iREN)
                    w_next = ISVC;
            end
            ISVC: begin
                // A dropped strobe is an abort: no RAM strobe, no completion pulse.
                if (!bus.iREN) begin
                    w_next = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    w_ramaddr  = bus.iaddr;
                    if (bus.ramstate == RAM_ACCESS) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        w_icomp   = 1'b1;
                        w_next    = IDLE;
                    end
                end
            end
            DSVC: begin
                if (!w_dreq) begin
                    w_next = IDLE;
                end else begin
                    w_ramaddr = bus.daddr;
                    if (bus.dWEN) begin
                        bus.ramWEN = 1'b1;
                        w_ramstore = bus.dstore;
                    end else begin
                        bus.ramREN = 1'b1;
                    end
                    if (bus.ramstate == RAM_ACCESS) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.dWEN ? '0 : bus.ramload;
                        w_dcomp   = 1'b1;
                        w_next    = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.ramaddr  = w_ramaddr;
    assign bus.ramstore = w_ramstore;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: expected completions are queued at issue time
// and a negedge monitor pops/compares whenever iwait or dwait goes low.
module tb_cache_mem_arbiter;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    logic rl_auto;
    logic [31:0] rl_fixed;
    exp_t q[$];
    int total = 0;
    int bad = 0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // RAM data: fixed word, or an address-derived word so each access is distinguishable.
    assign bus.ramload = rl_auto ? (bus.ramaddr + 32'h1000_0000) : rl_fixed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic check_resp(input bit is_d, input logic [31:0] data);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp is_d=%0d data=%h t=%0t", is_d, data, $time);
        end else begin
            e = q.pop_front();
            chk("resp_kind", {31'd0, is_d}, {31'd0, e.is_d});
            chk("resp_data", data, e.data);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (!bus.iwait && !bus.dwait) begin
                total++;
                bad++;
                $display("FAIL both_wait_low t=%0t", $time);
            end
            if (!bus.iwait) check_resp(1'b0, bus.iload);
            if (!bus.dwait) check_resp(1'b1, bus.dload);
        end
    end

    // Both caches request; each drops or re-issues (next word) after its completion.
    task automatic drive_pair(input int ni, input int nd);
        int ci = 0;
        int cd = 0;
        int guard = 0;
        logic iw, dw;
        bus.iaddr = 32'h80;
        bus.daddr = 32'h300;
        bus.iREN  = (ni > 0);
        bus.dREN  = (nd > 0);
        while ((ci < ni || cd < nd) && guard < 100) begin
            @(negedge CLK);
            iw = bus.iwait;
            dw = bus.dwait;
            @(posedge CLK);
            #1;
            if (!iw) begin
                ci++;
                if (ci < ni) bus.iaddr = bus.iaddr + 32'd4;
                else bus.iREN = 1'b0;
            end
            if (!dw) begin
                cd++;
                if (cd < nd) bus.daddr = bus.daddr + 32'd4;
                else bus.dREN = 1'b0;
            end
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL pair_timeout ci=%0d cd=%0d", ci, cd);
            bus.iREN = 1'b0;
            bus.dREN = 1'b0;
        end
    endtask

    initial begin
        nRST = 1'b0;
        rl_auto = 1'b0;
        rl_fixed = 32'h0;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = RS_FREE;
        #2;
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        chk("rst_ramren", bus.ramREN, 0);
        chk("rst_ramwen", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        @(posedge CLK); #2 nRST = 1'b1;

        // Instruction fill: 3 BUSY cycles then ACCESS.
        @(posedge CLK); #1;
        rl_fixed = 32'h2108_0004; bus.iaddr = 32'h40; bus.ramstate = RS_BUSY; bus.iREN = 1'b1;
        push(1'b0, 32'h2108_0004);
        @(negedge CLK);
        chk("i_grant_no_strobe", bus.ramREN, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("i_ramren", bus.ramREN, 1);
            chk("i_ramaddr", bus.ramaddr, 32'h40);
            chk("i_wait_busy", bus.iwait, 1);
        end
        @(posedge CLK); #1 bus.ramstate = RS_ACCESS;
        @(posedge CLK); #1 bus.iREN = 1'b0; bus.ramstate = RS_FREE;
        @(negedge CLK);
        chk("i_idle_ramren", bus.ramREN, 0);
        chk("i_idle_iwait", bus.iwait, 1);

        // Write with dREN also high: write wins, dload reads as zero.
        @(posedge CLK); #1;
        rl_fixed = 32'h1234_5678; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.ramstate = RS_ACCESS;
        push(1'b1, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        chk("w_ramwen", bus.ramWEN, 1);
        chk("w_ramren", bus.ramREN, 0);
        chk("w_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        chk("w_ramaddr", bus.ramaddr, 32'h100);
        @(posedge CLK); #1 bus.dWEN = 1'b0; bus.dREN = 1'b0;
        @(negedge CLK);
        chk("w_idle_ramwen", bus.ramWEN, 0);

        // Abort: iREN drops in ISVC; ACCESS in the drop cycle must not complete.
        @(posedge CLK); #1;
        bus.iaddr = 32'h44; bus.ramstate = RS_BUSY; bus.iREN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("ab_ramren", bus.ramREN, 1);
        @(posedge CLK); #1 bus.iREN = 1'b0; bus.ramstate = RS_ACCESS;
        @(negedge CLK);
        chk("ab_drop_ramren", bus.ramREN, 0);
        chk("ab_drop_iwait", bus.iwait, 1);
        @(posedge CLK); #1 bus.ramstate = RS_FREE;
        @(negedge CLK);
        chk("ab_next_ramren", bus.ramREN, 0);
        chk("ab_next_iwait", bus.iwait, 1);

        // Read of 0x200 with two ERROR cycles before ACCESS.
        @(posedge CLK); #1;
        rl_auto = 1'b1; bus.daddr = 32'h200; bus.ramstate = RS_ERROR; bus.dREN = 1'b1;
        push(1'b1, 32'h1000_0200);
        @(negedge CLK);
        repeat (2) begin
            @(negedge CLK);
            chk("err_dwait", bus.dwait, 1);
            chk("err_ramren", bus.ramREN, 1);
        end
        @(posedge CLK); #1 bus.ramstate = RS_ACCESS;
        @(posedge CLK); #1 bus.dREN = 1'b0;

        // Simultaneous requests, single then repeated.
        @(posedge CLK); #1;
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b0, 32'h1000_0080); push(1'b1, 32'h1000_0300);
`else
        push(1'b1, 32'h1000_0300); push(1'b0, 32'h1000_0080);
`endif
        drive_pair(1, 1);
        @(posedge CLK); #1;
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b0, 32'h1000_0080); push(1'b1, 32'h1000_0300);
        push(1'b0, 32'h1000_0084); push(1'b1, 32'h1000_0304);
`else
        push(1'b1, 32'h1000_0300); push(1'b1, 32'h1000_0304);
        push(1'b0, 32'h1000_0080); push(1'b0, 32'h1000_0084);
`endif
        drive_pair(2, 2);

        // Reset mid-DSVC: outputs return to reset values without waiting for a clock.
        @(posedge CLK); #1;
        bus.daddr = 32'h400; bus.ramstate = RS_BUSY; bus.dREN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rd_ramren", bus.ramREN, 1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_mid_iwait", bus.iwait, 1);
        chk("rst_mid_dwait", bus.dwait, 1);
        chk("rst_mid_ramren", bus.ramREN, 0);
        chk("rst_mid_ramwen", bus.ramWEN, 0);
        bus.dREN = 1'b0;
        @(posedge CLK); #2 nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_ramren", bus.ramREN, 0);
        chk("post_rst_dwait", bus.dwait, 1);
        @(posedge CLK); #1;
        bus.ramstate = RS_ACCESS; bus.dREN = 1'b1;
        push(1'b1, 32'h1000_0400);
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK); #1 bus.dREN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("pending_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
